// File: rtl/aux_uart_boot_loader.sv
// UART (8N1) boot loader: length-prefixed image -> 32-bit LE word writes, CPU held until done.
// mem_we one cycle after 4th byte strobe; no backpressure on rx, target memory must accept every write.
module aux_uart_boot_loader #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD          = 115200,
  parameter int ADDR_W        = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              frame_error
);
  localparam int DIV   = (CLK_FREQUENCY + BAUD / 2) / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {L_LEN0, L_LEN1, L_DATA, L_DONE} ld_state_t;

  rx_state_t        rx_state, rx_next;
  ld_state_t        ld_state, ld_next;
  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             byte_vld;
  logic             fall, half_tick, bit_tick;
  logic [15:0]      length, word_idx;
  logic [1:0]       lane;
  logic [23:0]      part;

  assign fall      = rx_prev & ~rx_s2;
  assign half_tick = (baud_cnt == CNT_W'(HALF - 1));
  assign bit_tick  = (baud_cnt == CNT_W'(DIV - 1));

  // Synchronizer resets to the idle-high level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      ld_state <= L_LEN0;
    end else begin
      rx_state <= rx_next;
      ld_state <= ld_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:      if (fall) rx_next = RX_START;
      RX_START:     if (half_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (bit_tick) rx_next = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s2) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt    <= '0;
      bit_idx     <= '0;
      rx_byte     <= '0;
      byte_vld    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      // Counter restarts on every state change so each phase times from its own entry.
      if (rx_state != rx_next || rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH || bit_tick)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + CNT_W'(1);
      if (rx_state == RX_START)
        bit_idx <= '0;
      if (rx_state == RX_DATA && bit_tick) begin
        rx_byte <= {rx_s2, rx_byte[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (rx_state == RX_STOP && bit_tick) begin
        if (rx_s2) byte_vld <= 1'b1;
        else       frame_error <= 1'b1;
      end
    end
  end

  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      L_LEN0: if (byte_vld) ld_next = L_LEN1;
      L_LEN1: if (byte_vld) ld_next = ({rx_byte, length[7:0]} == 16'd0) ? L_DONE : L_DATA;
      // Completion is seen one cycle after the final write so boot_done trails mem_we.
      L_DATA: if (mem_we && word_idx == length) ld_next = L_DONE;
      L_DONE: ld_next = L_DONE;
      default: ld_next = L_LEN0;
    endcase
  end

  always_comb begin
    boot_done = (ld_state == L_DONE);
    cpu_hold  = ~boot_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      length    <= '0;
      word_idx  <= '0;
      lane      <= '0;
      part      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (byte_vld) begin
        case (ld_state)
          L_LEN0: length[7:0] <= rx_byte;
          L_LEN1: begin
            length[15:8] <= rx_byte;
            word_idx     <= '0;
            lane         <= '0;
          end
          L_DATA: begin
            if (lane == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= ADDR_W'(word_idx);
              mem_wdata <= {rx_byte, part};
              word_idx  <= word_idx + 16'd1;
              lane      <= '0;
            end else begin
              part[{lane, 3'b000} +: 8] <= rx_byte;
              lane <= lane + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aux_uart_boot_loader.sv
// Bench for aux_uart_boot_loader: directed UART frames, transaction-level image model, per-cycle compare.
module tb_aux_uart_boot_loader;
  localparam int DIV = 16;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          reset, rx;
  logic          mem_we, cpu_hold, boot_done, frame_error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  always #5 clk = ~clk;

  aux_uart_boot_loader #(.CLK_FREQUENCY(16), .BAUD(1), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .boot_done(boot_done), .frame_error(frame_error)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, frame_start = 0, last_we_cyc = 0, done_cyc = 0, nwrites = 0, w0;
  bit chk_en, busy, we_d, bd_d;
  logic [7:0] img[$];
  wr_t e;

  // Image model: bytes in, expected writes and final flags out, no notion of cycles.
  wr_t exp_q[$];
  int m_len, m_nlen, m_widx, m_nbyte;
  logic [31:0] m_word, m_hold_data;
  logic [AW-1:0] m_hold_addr;
  bit m_done, m_ferr;

  function automatic void model_reset();
    exp_q.delete();
    m_len = 0; m_nlen = 0; m_widx = 0; m_nbyte = 0; m_word = 0;
    m_done = 0; m_ferr = 0; m_hold_addr = 0; m_hold_data = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    wr_t w;
    if (m_done) return;
    if (m_nlen < 2) begin
      m_len = m_len | (int'(b) << (8 * m_nlen));
      m_nlen++;
      if (m_nlen == 2 && m_len == 0) m_done = 1;
      return;
    end
    m_word = m_word | (32'(b) << (8 * m_nbyte));
    m_nbyte++;
    if (m_nbyte == 4) begin
      w.addr = AW'(m_widx % (1 << AW));
      w.data = m_word;
      exp_q.push_back(w);
      m_widx++; m_nbyte = 0; m_word = 0;
      if (m_widx == m_len) m_done = 1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      if (mem_we) begin
        check("we_not_back_to_back", we_d, 0);
        nwrites++;
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
          m_hold_addr = e.addr;
          m_hold_data = e.data;
        end
      end else begin
        check("hold_addr", mem_addr, m_hold_addr);
        check("hold_data", mem_wdata, m_hold_data);
      end
      if (boot_done && !bd_d) begin
        done_cyc = cyc;
        if (m_len != 0) check("done_after_last_we", we_d, 1);
      end
      if (!busy) begin
        check("boot_done", boot_done, m_done);
        check("cpu_hold", cpu_hold, !m_done);
        check("frame_error", frame_error, m_ferr);
      end
    end
    we_d = mem_we;
    bd_d = boot_done;
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    busy = 1;
    if (stop_ok) model_byte(b);
    else m_ferr = 1;
    frame_start = cyc;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_ok;
    repeat (DIV) @(negedge clk);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
    end
    busy = 0;
  endtask

  task automatic send_img();
    foreach (img[i]) send_frame(img[i], 1'b1);
  endtask

  task automatic do_reset();
    chk_en = 0;
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_boot_done", boot_done, 0);
    check("rst_frame_error", frame_error, 0);
    reset = 1'b0;
    model_reset();
    w0 = nwrites;
    chk_en = 1;
    @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx = 1'b1; chk_en = 0; busy = 0;
    model_reset();
    repeat (3) @(negedge clk);

    // Partial image: length 256, only two data bytes, nothing written.
    do_reset();
    img = '{8'h00, 8'h01, 8'h00, 8'h00};
    send_img();
    repeat (200) @(negedge clk);
    check("t1a_writes", nwrites - w0, 0);
    check("t1a_cpu_hold", cpu_hold, 1);

    // Single word image, exact latencies.
    do_reset();
    img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_img();
    check("t1_writes", nwrites - w0, 1);
    check("t1_addr", mem_addr, 0);
    check("t1_wdata", mem_wdata, 32'h12345678);
    check("t1_we_latency", last_we_cyc - frame_start, 156);
    check("t1_done_after_we", done_cyc - last_we_cyc, 1);
    check("t1_cpu_hold", cpu_hold, 0);
    check("t1_pending", exp_q.size(), 0);

    // Three words back-to-back.
    do_reset();
    img = '{8'h03, 8'h00};
    for (int k = 0; k < 12; k++) img.push_back(8'(8'h10 + k));
    send_img();
    check("t2_writes", nwrites - w0, 3);
    check("t2_addr", mem_addr, 2);
    check("t2_wdata", mem_wdata, 32'h1B1A1918);
    check("t2_pending", exp_q.size(), 0);

    // Zero length: done right after the second length byte, later bytes ignored.
    do_reset();
    img = '{8'h00, 8'h00};
    send_img();
    check("t3_done_latency", done_cyc - frame_start, 156);
    check("t3_boot_done", boot_done, 1);
    img = '{8'hAB, 8'hCD, 8'hEF, 8'h01};
    send_img();
    check("t3_writes", nwrites - w0, 0);

    // Framing error between data bytes: byte dropped, word completes.
    do_reset();
    img = '{8'h01, 8'h00, 8'h11, 8'h22};
    send_img();
    send_frame(8'h99, 1'b0);
    check("t4_frame_error", frame_error, 1);
    img = '{8'h33, 8'h44};
    send_img();
    check("t4_wdata", mem_wdata, 32'h44332211);
    check("t4_frame_error_sticky", frame_error, 1);
    check("t4_pending", exp_q.size(), 0);

    // Short low glitch mid-word is rejected.
    do_reset();
    img = '{8'h01, 8'h00, 8'hAA};
    send_img();
    busy = 1;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    busy = 0;
    img = '{8'hBB, 8'hCC, 8'hDD};
    send_img();
    check("t5_writes", nwrites - w0, 1);
    check("t5_wdata", mem_wdata, 32'hDDCCBBAA);

    // Reset after two bytes of the second word, then full resend.
    do_reset();
    img = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_img();
    check("t6_first_wdata", mem_wdata, 32'h04030201);
    do_reset();
    img = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_img();
    check("t6_writes", nwrites - w0, 1);
    check("t6_addr", mem_addr, 0);
    check("t6_wdata", mem_wdata, 32'hEFBEADDE);

    // Five words into a four-word memory: last write wraps to address 0.
    do_reset();
    img = '{8'h05, 8'h00};
    for (int k = 0; k < 20; k++) img.push_back(8'(8'h40 + k));
    send_img();
    check("t7_writes", nwrites - w0, 5);
    check("t7_addr_wrap", mem_addr, 0);
    check("t7_wdata", mem_wdata, 32'h53525150);
    check("t7_pending", exp_q.size(), 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
